frame_feeder: RTL and testbench

Upstream stage of the 256×256 RGB transpose adapter. Accepts a bursty valid/ready pixel stream into a line-buffer FIFO and, once one full line is buffered, drives the adapter's free-running interface at one pixel per clock. It sequences the write phase (mode 0) and the read phase (mode 1) over 65536 cycles each, then returns to fill for the next frame. It also flags FIFO underrun.

---
 rtl/rotate_pkg.sv | 9 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/frame_feeder.sv | 152 +++++++++++++++
 tb/tb_frame_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared constants and sequencer state encoding for the transpose adapter front end.
package rotate_pkg;
  localparam int PIX_W      = 24;
  localparam int LINE_PIX   = 256;
  localparam int FRAME_PIX  = 65536;
  localparam int FIFO_DEPTH = 512;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} feeder_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty and first-word-fall-through read data.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/frame_feeder.sv
// Buffers a bursty pixel stream and feeds the transpose adapter one pixel per clock,
// sequencing a write frame (mode 0) followed by a read frame (mode 1).
module frame_feeder #(
  parameter int FIFO_DEPTH = rotate_pkg::FIFO_DEPTH,
  parameter int LINE_PIX   = rotate_pkg::LINE_PIX,
  parameter int FRAME_PIX  = rotate_pkg::FRAME_PIX
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [rotate_pkg::PIX_W-1:0] in_data,
  input  logic                         in_sof,
  output logic                         adp_rst,
  output logic                         adp_mode,
  output logic                         adp_start,
  output logic [rotate_pkg::PIX_W-1:0] adp_data,
  output logic                         adp_jump,
  output logic                         busy,
  output logic                         underrun,
  output logic                         frame_done
);
  import rotate_pkg::*;

  localparam int CW = $clog2(FRAME_PIX);
  localparam int LW = $clog2(LINE_PIX);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FILL_TH  = (AW+1)'(LINE_PIX);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_PIX - 1);

  feeder_state_t    r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_alive;
  logic             r_adp_rst;
  logic             r_mode;
  logic             r_start;
  logic [PIX_W-1:0] r_data;
  logic             r_jump;
  logic             r_busy;
  logic             r_under;
  logic             r_done;

  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [PIX_W-1:0] w_rd_data;
  logic             w_push;
  logic             w_pop;
  logic             w_fill_ok;
  logic             w_last;
  logic [CW-1:0]    w_cnt_inc;

  // in_ready depends only on registers, so there is no in_valid -> in_ready path.
  assign in_ready  = r_alive & ~w_full;
  assign w_push    = in_valid & in_ready & ((r_state != IDLE) | in_sof);
  assign w_fill_ok = (w_count >= FILL_TH);
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_pop     = ((r_state == FILL) & w_fill_ok) | ((r_state == STREAM) & ~w_last);

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wr_data (in_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_alive   <= 1'b0;
      r_adp_rst <= 1'b1;
      r_mode    <= 1'b0;
      r_start   <= 1'b0;
      r_data    <= '0;
      r_jump    <= 1'b0;
      r_busy    <= 1'b0;
      r_under   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_jump  <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_state <= FILL;
            r_busy  <= 1'b1;
          end
        end
        FILL: begin
          // Release the adapter on the same edge pixel 0 appears so it sees x=y=0 with it.
          if (w_fill_ok) begin
            r_state   <= STREAM;
            r_adp_rst <= 1'b0;
            r_start   <= 1'b1;
            r_mode    <= 1'b0;
            r_data    <= w_rd_data;
            r_cnt     <= '0;
            r_jump    <= 1'b1;
            r_under   <= 1'b0;
          end
        end
        STREAM: begin
          if (w_last) begin
            r_state <= DRAIN;
            r_mode  <= 1'b1;
            r_data  <= '0;
            r_cnt   <= '0;
          end else begin
            // The counter advances even on an empty FIFO to keep adapter x,y aligned.
            r_cnt  <= w_cnt_inc;
            r_jump <= (w_cnt_inc[LW-1:0] == '0);
            r_data <= w_empty ? '0 : w_rd_data;
            if (w_empty) r_under <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_last) begin
            r_state   <= FILL;
            r_mode    <= 1'b0;
            r_start   <= 1'b0;
            r_adp_rst <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_done <= (w_cnt_inc == LAST_CNT);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign adp_rst    = r_adp_rst;
  assign adp_mode   = r_mode;
  assign adp_start  = r_start;
  assign adp_data   = r_data;
  assign adp_jump   = r_jump;
  assign busy       = r_busy;
  assign underrun   = r_under;
  assign frame_done = r_done;
endmodule

// File: tb/tb_frame_feeder.sv
// Directed bench for frame_feeder with a reduced geometry (16-pixel lines, 256-pixel frames,
// 32-entry FIFO); a negedge engine drives the source and scoreboards the adapter side.
module tb_frame_feeder;
  localparam int L = 16;
  localparam int F = 256;
  localparam int D = 32;
  localparam logic [23:0] JUNK = 24'hAAAAAA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        adp_rst, adp_mode, adp_start, adp_jump, busy, underrun, frame_done;
  logic [23:0] adp_data;

  always #5 clk = ~clk;

  frame_feeder #(.FIFO_DEPTH(D), .LINE_PIX(L), .FRAME_PIX(F)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .adp_rst(adp_rst), .adp_mode(adp_mode), .adp_start(adp_start),
    .adp_data(adp_data), .adp_jump(adp_jump), .busy(busy), .underrun(underrun),
    .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;

  // Source configuration, written only by the test tasks.
  int          cfg_junk = 0;
  int          cfg_limit = 0;
  logic [23:0] cfg_base = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine state and statistics, written only by the engine.
  logic [23:0] q[$];
  logic        staged_v;
  logic [23:0] staged_d;
  logic        armed;
  int junk_left, real_sent;
  int n_entries, entry_cyc, sof_cyc, s_idx, stream_len, last_stream_len, n_stream_ends;
  int s_jumps, last_jumps, drain_len, last_drain_len, n_done, done_idx, fill_rst;
  int bad_data, bad_jump, bad_start, bad_under, ready_low, max_occ;
  logic [23:0] first_data;
  logic        under_at_entry;
  logic        p_rst, p_stream, p_mode;

  always @(negedge clk) begin : engine
    logic st, v, sof, fire;
    logic [23:0] d, exp_d;
    if (!rst_n) begin
      in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
      q.delete(); staged_v = 1'b0; staged_d = '0; armed = 1'b1;
      junk_left = cfg_junk; real_sent = 0;
      n_entries = 0; entry_cyc = 0; sof_cyc = 0; s_idx = 0; stream_len = 0;
      last_stream_len = 0; n_stream_ends = 0; s_jumps = 0; last_jumps = 0;
      drain_len = 0; last_drain_len = 0; n_done = 0; done_idx = -1; fill_rst = 0;
      bad_data = 0; bad_jump = 0; bad_start = 0; bad_under = 0; ready_low = 0; max_occ = 0;
      first_data = '0; under_at_entry = 1'b0;
      p_rst = 1'b1; p_stream = 1'b0; p_mode = 1'b0;
    end else begin
      st = busy && !adp_rst && !adp_mode;
      if (p_rst && !adp_rst) begin
        n_entries++; entry_cyc = cyc; first_data = adp_data; under_at_entry = underrun;
        s_idx = 0; stream_len = 0; s_jumps = 0;
      end
      if (st) begin
        if (q.size() > 0) exp_d = q.pop_front();
        else begin
          exp_d = '0;
          if (underrun !== 1'b1) bad_under++;
        end
        if (adp_data !== exp_d) bad_data++;
        if (adp_jump !== (s_idx % L == 0)) bad_jump++;
        if (adp_jump) s_jumps++;
        if (adp_start !== 1'b1) bad_start++;
        s_idx++; stream_len++;
      end else if (adp_jump) bad_jump++;
      if (p_stream && !st) begin
        last_stream_len = stream_len; last_jumps = s_jumps; n_stream_ends++;
      end
      if (adp_mode) begin
        if (adp_start !== 1'b1) bad_start++;
        if (frame_done) begin n_done++; done_idx = drain_len; end
        if (!in_ready) ready_low++;
        drain_len++;
      end else if (frame_done) n_done++;
      if (!adp_mode && !st && adp_start) bad_start++;
      if (p_mode && !adp_mode) begin last_drain_len = drain_len; drain_len = 0; end
      if (busy && adp_rst && n_entries > 0) fill_rst++;
      p_rst = adp_rst; p_stream = st; p_mode = adp_mode;

      // The pixel staged last negedge was written at the edge just passed; now poppable.
      if (staged_v) q.push_back(staged_d);
      staged_v = 1'b0;
      if (q.size() > max_occ) max_occ = q.size();

      if (junk_left > 0) begin v = 1'b1; d = JUNK; sof = 1'b0; end
      else if (real_sent < cfg_limit) begin
        v = 1'b1; d = cfg_base + 24'(real_sent); sof = (real_sent == 0);
      end else begin v = 1'b0; d = '0; sof = 1'b0; end
      in_valid = v; in_data = d; in_sof = sof;
      fire = v && in_ready;
      if (fire) begin
        if (junk_left > 0) junk_left--; else real_sent++;
        if (!armed || sof) begin staged_v = 1'b1; staged_d = d; end
        if (sof) begin armed = 1'b0; sof_cyc = cyc + 1; end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cfg_junk = 0; cfg_limit = 0; cfg_base = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tests++; if (adp_rst !== 1'b1)   begin fails++; $display("FAIL rst_adp_rst: got %b want 1", adp_rst); end
    tests++; if (adp_mode !== 1'b0)  begin fails++; $display("FAIL rst_adp_mode: got %b want 0", adp_mode); end
    tests++; if (adp_start !== 1'b0) begin fails++; $display("FAIL rst_adp_start: got %b want 0", adp_start); end
    tests++; if (adp_data !== 24'h0) begin fails++; $display("FAIL rst_adp_data: got %h want 0", adp_data); end
    tests++; if (adp_jump !== 1'b0)  begin fails++; $display("FAIL rst_adp_jump: got %b want 0", adp_jump); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (underrun !== 1'b0)  begin fails++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL post_rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_first_frame();
    cfg_junk = 3; cfg_limit = 100000; cfg_base = 24'h100000;
    do_reset();
    for (int i = 0; i < 300 && n_entries < 1; i++) begin @(posedge clk); #1; end
    tests++; if (n_entries < 1) begin fails++; $display("FAIL ff_entry_timeout: entries %0d want >=1", n_entries); end
    tests++; if (entry_cyc - sof_cyc !== L) begin fails++; $display("FAIL ff_start_latency: got %0d want %0d", entry_cyc - sof_cyc, L); end
    tests++; if (first_data !== 24'h100000) begin fails++; $display("FAIL ff_first_pixel: got %h want 100000", first_data); end
    for (int i = 0; i < 2000 && n_entries < 2; i++) begin @(posedge clk); #1; end
    tests++; if (n_entries < 2) begin fails++; $display("FAIL ff_second_entry_timeout: entries %0d want >=2", n_entries); end
    tests++; if (last_drain_len !== F) begin fails++; $display("FAIL ff_mode_len: got %0d want %0d", last_drain_len, F); end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL ff_done_count: got %0d want 1", n_done); end
    tests++; if (done_idx !== F - 1) begin fails++; $display("FAIL ff_done_pos: got %0d want %0d", done_idx, F - 1); end
    tests++; if (fill_rst < 1) begin fails++; $display("FAIL ff_refill_rst: got %0d want >=1", fill_rst); end
    tests++; if (ready_low < 1) begin fails++; $display("FAIL ff_ready_drop: got %0d want >=1", ready_low); end
    tests++; if (max_occ !== D) begin fails++; $display("FAIL ff_fifo_peak: got %0d want %0d", max_occ, D); end
    for (int i = 0; i < 2000 && n_stream_ends < 2; i++) begin @(posedge clk); #1; end
    tests++; if (last_stream_len !== F) begin fails++; $display("FAIL ff_stream_len: got %0d want %0d", last_stream_len, F); end
    tests++; if (last_jumps !== F / L) begin fails++; $display("FAIL ff_jump_count: got %0d want %0d", last_jumps, F / L); end
    tests++; if (bad_jump !== 0) begin fails++; $display("FAIL ff_jump_align: got %0d bad want 0", bad_jump); end
    tests++; if (bad_data !== 0) begin fails++; $display("FAIL ff_scoreboard: got %0d bad pixels want 0", bad_data); end
    tests++; if (bad_start !== 0) begin fails++; $display("FAIL ff_adp_start: got %0d bad want 0", bad_start); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ff_no_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun();
    cfg_junk = 0; cfg_limit = L + 4; cfg_base = 24'h200000;
    do_reset();
    for (int i = 0; i < 600 && n_stream_ends < 1; i++) begin @(posedge clk); #1; end
    tests++; if (n_stream_ends < 1) begin fails++; $display("FAIL ur_stream_timeout: ends %0d want >=1", n_stream_ends); end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_sticky: got %b want 1", underrun); end
    tests++; if (last_stream_len !== F) begin fails++; $display("FAIL ur_stream_len: got %0d want %0d", last_stream_len, F); end
    tests++; if (bad_data !== 0) begin fails++; $display("FAIL ur_zero_fill: got %0d bad pixels want 0", bad_data); end
    tests++; if (bad_under !== 0) begin fails++; $display("FAIL ur_flag_timing: got %0d bad want 0", bad_under); end
    for (int i = 0; i < 600 && n_done < 1; i++) begin @(posedge clk); #1; end
    cfg_limit = 100000;
    for (int i = 0; i < 600 && n_entries < 2; i++) begin @(posedge clk); #1; end
    tests++; if (n_entries < 2) begin fails++; $display("FAIL ur_restart_timeout: entries %0d want >=2", n_entries); end
    tests++; if (under_at_entry !== 1'b0) begin fails++; $display("FAIL ur_clear_on_stream: got %b want 0", under_at_entry); end
    repeat (40) @(posedge clk);
    #1;
    tests++; if (bad_data !== 0) begin fails++; $display("FAIL ur_resume_data: got %0d bad pixels want 0", bad_data); end
  endtask

  task automatic test_midreset();
    cfg_junk = 0; cfg_limit = 100000; cfg_base = 24'h300000;
    do_reset();
    for (int i = 0; i < 300 && n_entries < 1; i++) begin @(posedge clk); #1; end
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++; if (adp_rst !== 1'b1)   begin fails++; $display("FAIL mr_adp_rst: got %b want 1", adp_rst); end
    tests++; if (adp_start !== 1'b0) begin fails++; $display("FAIL mr_adp_start: got %b want 0", adp_start); end
    tests++; if (adp_data !== 24'h0) begin fails++; $display("FAIL mr_adp_data: got %h want 0", adp_data); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL mr_busy: got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL mr_in_ready: got %b want 0", in_ready); end
    tests++; if (adp_mode !== 1'b0 || adp_jump !== 1'b0 || underrun !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL mr_flags: mode %b jump %b under %b done %b want all 0", adp_mode, adp_jump, underrun, frame_done);
    end
    tests++; if (dut.u_fifo.o_count !== '0) begin fails++; $display("FAIL mr_fifo_count: got %0d want 0", dut.u_fifo.o_count); end
    cfg_base = 24'h400000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 300 && n_entries < 1; i++) begin @(posedge clk); #1; end
    tests++; if (first_data !== 24'h400000) begin fails++; $display("FAIL mr_fresh_first: got %h want 400000", first_data); end
    for (int i = 0; i < 600 && n_stream_ends < 1; i++) begin @(posedge clk); #1; end
    tests++; if (last_stream_len !== F) begin fails++; $display("FAIL mr_stream_len: got %0d want %0d", last_stream_len, F); end
    tests++; if (bad_data !== 0) begin fails++; $display("FAIL mr_scoreboard: got %0d bad pixels want 0", bad_data); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
